// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/sequence controller for a small
// accumulator datapath. One instruction in flight; IDLE -> FETCH -> EXEC
// (-> MEMWAIT for loads) -> FETCH ... until a halt instruction parks it in HALT.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal opcode
// sets the sticky err flag and halts without retiring. When it is undefined, an
// illegal opcode behaves as a nop and err is tied low.
//
// ROM handshake: instr_req is the request and instr_valid is the reply. An
// instruction transfers on a rising edge where instr_req=1 and instr_valid=1.
// instr_req is held high until that edge, and instr_valid is ignored while
// instr_req is low.
module alu_sequencer #(
   parameter int                PC_W   = 8,
   parameter logic [4*PC_W-1:0] BR_LUT = '0,
   parameter int                CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [PC_W-1:0]  pc,
   output logic             instr_req,
   input  logic [8:0]       instr,
   input  logic             instr_valid,
   input  logic             branch_bool,
   output logic [3:0]       alu_cmd,
   output logic [2:0]       ra_addr,
   output logic [7:0]       imm,
   output logic             reg_we,
   output logic             mem_rd,
   output logic             mem_we,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_XOR   = 4'b0010;
   localparam logic [3:0] OP_BNE   = 4'b0011;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_LSH   = 4'b0110;
   localparam logic [3:0] OP_RSH   = 4'b0111;
   localparam logic [3:0] OP_LOADI = 4'b1000;
   localparam logic [3:0] OP_PARI  = 4'b1001;
   localparam logic [3:0] OP_HALT  = 4'b1110;
   localparam logic [3:0] OP_NOP   = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_EXEC    = 3'd2,
      S_MEMWAIT = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [PC_W-1:0] br_target;
   logic [8:0]      ir;
   logic [3:0]      op;
   logic            retire;

   assign op        = ir[8:5];
   assign br_target = BR_LUT[ir[1:0]*PC_W +: PC_W];

`ifdef ILLEGAL_TRAP_EN
   logic illegal;
   logic err_set;

   // Flag the opcodes that have no defined meaning.
   always_comb begin
      illegal = 1'b0;
      case (op)
         4'b0101, 4'b1010, 4'b1011, 4'b1100, 4'b1101: illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end
`endif

   // Next-state, next-PC and decoded strobes; all outputs default to idle values.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      retire    = 1'b0;
      instr_req = 1'b0;
      alu_cmd   = OP_NOP;
      ra_addr   = 3'd0;
      imm       = 8'd0;
      reg_we    = 1'b0;
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      err_set   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
            end
         end
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) state_nx = S_EXEC;
         end
         S_EXEC: begin
            alu_cmd  = op;
            ra_addr  = ir[4:2];
            imm      = {3'b000, ir[4:0]};
            state_nx = S_FETCH;
            pc_nx    = pc + PC_W'(1);
            retire   = 1'b1;
            case (op)
               OP_LOAD: begin
                  // The load retires one cycle later, from MEMWAIT.
                  mem_rd   = 1'b1;
                  state_nx = S_MEMWAIT;
                  pc_nx    = pc;
                  retire   = 1'b0;
               end
               OP_STORE: mem_we = 1'b1;
               OP_XOR, OP_ADD, OP_LSH, OP_RSH, OP_PARI, OP_LOADI: reg_we = 1'b1;
               OP_BNE: begin
                  if (branch_bool) pc_nx = br_target;
               end
               OP_HALT: begin
                  state_nx = S_HALT;
                  pc_nx    = pc;
               end
               default: ;
            endcase
`ifdef ILLEGAL_TRAP_EN
            if (illegal) begin
               state_nx = S_HALT;
               pc_nx    = pc;
               retire   = 1'b0;
               err_set  = 1'b1;
            end
`endif
         end
         S_MEMWAIT: begin
            alu_cmd  = op;
            ra_addr  = ir[4:2];
            imm      = {3'b000, ir[4:0]};
            mem_rd   = 1'b1;
            reg_we   = 1'b1;
            state_nx = S_FETCH;
            pc_nx    = pc + PC_W'(1);
            retire   = 1'b1;
         end
         S_HALT: begin
            done = 1'b1;
            if (start) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // PC, instruction latch and the saturating retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= '0;
         ir        <= '0;
         instr_cnt <= '0;
      end else begin
         pc <= pc_nx;
         if (state == S_FETCH && instr_valid) ir <= instr;
         if (retire && instr_cnt != {CNT_W{1'b1}}) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

`ifdef ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed programs with hand-computed checks,
// then a long randomized run checked cycle by cycle against an
// instruction-level model of the sequencer.
`timescale 1ns/1ps
module tb_alu_sequencer;

   localparam int PW = 8;
   localparam int CW = 4;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          instr_valid = 1'b0;
   logic          branch_bool = 1'b0;
   logic [8:0]    instr = '0;
   logic [PW-1:0] pc;
   logic          instr_req;
   logic [3:0]    alu_cmd;
   logic [2:0]    ra_addr;
   logic [7:0]    imm;
   logic          reg_we, mem_rd, mem_we, done, err;
   logic [CW-1:0] instr_cnt;

   always #5 clk = ~clk;

   alu_sequencer #(
      .PC_W   (PW),
      .BR_LUT ({8'hFE, 8'h40, 8'h10, 8'h00}),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pc          (pc),
      .instr_req   (instr_req),
      .instr       (instr),
      .instr_valid (instr_valid),
      .branch_bool (branch_bool),
      .alu_cmd     (alu_cmd),
      .ra_addr     (ra_addr),
      .imm         (imm),
      .reg_we      (reg_we),
      .mem_rd      (mem_rd),
      .mem_we      (mem_we),
      .done        (done),
      .err         (err),
      .instr_cnt   (instr_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- ROM responder ----------------
   logic [8:0] rom [256];
   int         rom_wait = 0;   // fixed wait states per fetch, -1 = random 0..2
   int         wait_left = 0;
   bit         noise = 1'b0;   // random instr_valid glitches while not fetching

   always @(posedge clk) begin
      #1;
      if (instr_req) begin
         if (wait_left == 0) begin
            instr_valid = 1'b1;
            instr       = rom[pc];
         end else begin
            instr_valid = 1'b0;
            instr       = 9'($urandom);
            wait_left--;
         end
      end else begin
         instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         instr       = 9'($urandom);
         wait_left   = (rom_wait < 0) ? int'($urandom_range(0, 2)) : rom_wait;
      end
   end

   // ---------------- instruction-level reference model ----------------
   localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2, M_RUN = 3;
   int            m_mode = M_IDLE;
   int            m_step = 0;
   logic [PW-1:0] m_pc = '0;
   logic [CW-1:0] m_cnt = '0;
   logic          m_err = 1'b0;
   logic [8:0]    m_ir = '0;
   logic [7:0]    lut [4] = '{8'h00, 8'h10, 8'h40, 8'hFE};

   function automatic bit op_illegal(input logic [3:0] op);
      return op inside {4'd5, [4'd10:4'd13]};
   endfunction

   function automatic bit writes_acc(input logic [3:0] op);
      return op inside {4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
   endfunction

   // Compare process: expected outputs for this cycle, then advance the model.
   always @(negedge clk) begin
      logic [PW-1:0] e_pc;
      logic          e_req, e_we, e_rd, e_wr, e_done, e_err, dec;
      logic [3:0]    e_alu, op;
      logic [2:0]    e_ra;
      logic [7:0]    e_imm;
      logic [CW-1:0] e_cnt;
      if (!rst_n) begin
         m_mode = M_IDLE; m_step = 0; m_pc = '0; m_cnt = '0; m_err = 1'b0; m_ir = '0;
      end
      e_pc = m_pc; e_req = 1'b0; e_alu = 4'hF; e_ra = '0; e_imm = '0;
      e_we = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_done = 1'b0;
      e_err = m_err; e_cnt = m_cnt; dec = 1'b0; op = m_ir[8:5];
      if (rst_n) begin
         case (m_mode)
            M_IDLE: if (start) begin m_mode = M_FETCH; m_pc = '0; end
            M_HALT: begin
               e_done = 1'b1;
               if (start) begin m_mode = M_FETCH; m_pc = '0; end
            end
            M_FETCH: begin
               e_req = 1'b1;
               if (instr_valid) begin m_ir = instr; m_mode = M_RUN; m_step = 0; end
            end
            default: begin
               dec   = 1'b1;
               e_alu = op;
               e_ra  = m_ir[4:2];
               e_imm = {3'b000, m_ir[4:0]};
               e_rd  = (op == 4'd0);
               e_wr  = (op == 4'd1);
               e_we  = (op == 4'd0) ? (m_step == 1) : writes_acc(op);
               if (op == 4'd0 && m_step == 0) begin
                  m_step = 1;
               end else if (TRAP && op_illegal(op)) begin
                  m_err  = 1'b1;
                  m_mode = M_HALT;
               end else begin
                  if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                  if (op == 4'd14) m_mode = M_HALT;
                  else begin
                     m_pc   = (op == 4'd3 && branch_bool) ? lut[m_ir[1:0]] : m_pc + 8'd1;
                     m_mode = M_FETCH;
                  end
               end
            end
         endcase
      end
      vectors++;
      if (pc !== e_pc || instr_req !== e_req || alu_cmd !== e_alu || reg_we !== e_we ||
          mem_rd !== e_rd || mem_we !== e_wr || done !== e_done || err !== e_err ||
          instr_cnt !== e_cnt || (dec && (ra_addr !== e_ra || imm !== e_imm))) begin
         miscompares++;
         $display("FAIL model t=%0t got pc=%h req=%b alu=%h ra=%h imm=%h we=%b rd=%b wr=%b done=%b err=%b cnt=%h want pc=%h req=%b alu=%h ra=%h imm=%h we=%b rd=%b wr=%b done=%b err=%b cnt=%h",
                  $time, pc, instr_req, alu_cmd, ra_addr, imm, reg_we, mem_rd, mem_we, done, err, instr_cnt,
                  e_pc, e_req, e_alu, e_ra, e_imm, e_we, e_rd, e_wr, e_done, e_err, e_cnt);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) rom[i] = 9'h1E0;
   endtask

   task automatic kick();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      fill_nop();
      do_reset();

      // reset values
      check("rst_pc", pc, 0);
      check("rst_req", instr_req, 0);
      check("rst_alu", alu_cmd, 4'hF);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cnt", instr_cnt, 0);

      // loadi 5, add r1, halt with a zero-wait ROM
      rom[0] = 9'h105; rom[1] = 9'h084; rom[2] = 9'h1C0;
      kick();                                   // cycle 1
      check("t1_req_c1", instr_req, 1);
      step(1);                                  // cycle 2: EXEC loadi
      check("t1_loadi_we", reg_we, 1);
      check("t1_loadi_imm", imm, 8'h05);
      check("t1_loadi_alu", alu_cmd, 4'h8);
      step(2);                                  // cycle 4: EXEC add
      check("t1_add_we", reg_we, 1);
      check("t1_add_ra", ra_addr, 1);
      step(2);                                  // cycle 6: EXEC halt
      check("t1_done_c6", done, 0);
      step(1);                                  // cycle 7: HALT
      check("t1_done_c7", done, 1);
      check("t1_cnt", instr_cnt, 3);
      check("t1_pc", pc, 2);

      // bne taken to BR_LUT[2], then not taken
      rom[0] = 9'h062; rom[8'h40] = 9'h062; rom[8'h41] = 9'h1C0;
      branch_bool = 1'b1;
      kick();                                   // c1 FETCH
      check("t2_pc0", pc, 0);
      step(2);                                  // c3 FETCH
      check("t2_taken_pc", pc, 8'h40);
      branch_bool = 1'b0;
      step(2);                                  // c5 FETCH
      check("t2_nottaken_pc", pc, 8'h41);
      step(2);                                  // c7 HALT
      check("t2_done", done, 1);
      check("t2_cnt", instr_cnt, 6);

      // PC wrap: branch to FE, nops at FE and FF, wrap to 0
      rom[0] = 9'h063; rom[8'hFE] = 9'h1E0; rom[8'hFF] = 9'h1E0; rom[1] = 9'h1C0;
      branch_bool = 1'b1;
      kick();
      step(2);                                  // c3
      check("t3_pc_fe", pc, 8'hFE);
      branch_bool = 1'b0;
      step(2);                                  // c5
      check("t3_pc_ff", pc, 8'hFF);
      step(2);                                  // c7
      check("t3_pc_wrap", pc, 8'h00);
      step(2);                                  // c9
      check("t3_pc_after", pc, 8'h01);
      step(2);                                  // c11
      check("t3_done", done, 1);
      check("t3_cnt", instr_cnt, 11);

      // load with 3 ROM wait states
      rom[0] = 9'h008; rom[1] = 9'h1C0;
      rom_wait = 3;
      step(1);
      kick();                                   // c1
      check("t4_req_c1", instr_req, 1);
      step(3);                                  // c4
      check("t4_req_c4", instr_req, 1);
      step(1);                                  // c5 EXEC
      check("t4_req_c5", instr_req, 0);
      check("t4_exec_rd", mem_rd, 1);
      check("t4_exec_we", reg_we, 0);
      check("t4_exec_alu", alu_cmd, 4'h0);
      step(1);                                  // c6 MEMWAIT
      check("t4_mw_rd", mem_rd, 1);
      check("t4_mw_we", reg_we, 1);
      step(1);                                  // c7 FETCH
      check("t4_pc_next", pc, 1);
      check("t4_rd_off", mem_rd, 0);
      step(5);                                  // c12 HALT
      check("t4_done", done, 1);
      check("t4_cnt", instr_cnt, 13);

      // reset during MEMWAIT
      rom_wait = 0;
      step(1);
      kick();                                   // c1
      step(2);                                  // c3 MEMWAIT
      check("t5_mw_rd", mem_rd, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_pc", pc, 0);
      check("t5_rst_req", instr_req, 0);
      check("t5_rst_alu", alu_cmd, 4'hF);
      check("t5_rst_rd", mem_rd, 0);
      check("t5_rst_we", reg_we, 0);
      check("t5_rst_ra", ra_addr, 0);
      check("t5_rst_imm", imm, 0);
      check("t5_rst_cnt", instr_cnt, 0);
      check("t5_rst_done", done, 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      check("t5_idle_req", instr_req, 0);
      check("t5_idle_pc", pc, 0);
      kick();
      check("t5_resume_req", instr_req, 1);
      check("t5_resume_pc", pc, 0);
      step(5);                                  // c6 HALT
      check("t5_done", done, 1);

      // illegal opcode 0101
      do_reset();
      rom[0] = 9'h0A0; rom[1] = 9'h1C0;
      kick();
      step(1);                                  // c2 EXEC illegal
      check("t6_we", reg_we, 0);
      check("t6_rd", mem_rd, 0);
      check("t6_wr", mem_we, 0);
      step(1);                                  // c3
      check("t6_done_c3", done, TRAP);
      check("t6_err_c3", err, TRAP);
      check("t6_cnt_c3", instr_cnt, TRAP ? 0 : 1);
      step(2);                                  // c5
      check("t6_done_c5", done, 1);
      check("t6_err_c5", err, TRAP);
      check("t6_cnt_c5", instr_cnt, TRAP ? 0 : 2);

      // counter saturation: 20 nops then halt
      do_reset();
      fill_nop();
      rom[20] = 9'h1C0;
      kick();
      step(44);
      check("t7_done", done, 1);
      check("t7_pc", pc, 20);
      check("t7_cnt_sat", instr_cnt, 15);

      // randomized run
      do_reset();
      for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
      noise    = 1'b1;
      rom_wait = -1;
      step(1);
      for (int i = 0; i < 3000; i++) begin
         start       = ($urandom_range(0, 3) == 0);
         branch_bool = 1'($urandom_range(0, 1));
         rst_n       = ($urandom_range(0, 499) != 0);
         step(1);
      end
      rst_n = 1'b1;
      start = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
